line_pad_streamer: RTL

- Transmit-side companion to the 3-tap horizontal window stage. Accepts raw row-major pixels over a valid/ready stream and re-emits each line with one replicated border pixel at each end.
- Each IMG_W-pixel line leaves as IMG_W+2 beats. This lets the downstream window enable (i_en) advance on every output beat and produce correctly padded windows at column 0 and column IMG_W-1.
- Generates start/end-of-line and start/end-of-frame markers for the filter datapath.

---
 rtl/line_pad_streamer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/line_pad_streamer.sv
// Line padding streamer: takes row-major pixels over valid/ready and re-emits
// each line with its first and last pixel replicated, plus line/frame markers.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for the first pixel of a line, output empty
// S_LPAD | left pad beat (copy of p0) presented with o_sol
// S_BODY | body beats p0..p[IMG_W-1], may bubble while upstream is idle
// S_RPAD | right pad beat (copy of p[IMG_W-1]) presented with o_eol
module line_pad_streamer #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_sol,
    output logic              o_eol,
    output logic              o_sof,
    output logic              o_eof
);

    localparam int COL_W = $clog2(IMG_W + 1);
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LPAD,
        S_BODY,
        S_RPAD
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [COL_W-1:0]  r_col, w_col_nxt;
    logic [ROW_W-1:0]  r_row, w_row_nxt;
    logic [DATA_W-1:0] r_data, w_data_nxt;
    logic [DATA_W-1:0] r_last, w_last_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_sol, w_sol_nxt;
    logic              r_eol, w_eol_nxt;
    logic              r_sof, w_sof_nxt;
    logic              r_eof, w_eof_nxt;

    logic              w_ready;
    logic              w_in_xfer;
    logic              w_out_xfer;

    // Body accepts a new pixel only when the current beat leaves (or none is held).
    assign w_ready    = (r_state == S_IDLE) ||
                        ((r_state == S_BODY) && (r_col < COL_LAST) && (!r_valid || i_ready));
    assign w_in_xfer  = i_valid && w_ready;
    assign w_out_xfer = r_valid && i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_data  <= '0;
            r_last  <= '0;
            r_valid <= 1'b0;
            r_sol   <= 1'b0;
            r_eol   <= 1'b0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_data  <= w_data_nxt;
            r_last  <= w_last_nxt;
            r_valid <= w_valid_nxt;
            r_sol   <= w_sol_nxt;
            r_eol   <= w_eol_nxt;
            r_sof   <= w_sof_nxt;
            r_eof   <= w_eof_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_data_nxt  = r_data;
        w_last_nxt  = r_last;
        w_valid_nxt = r_valid;
        w_sol_nxt   = r_sol;
        w_eol_nxt   = r_eol;
        w_sof_nxt   = r_sof;
        w_eof_nxt   = r_eof;
        case (r_state)
            S_IDLE: begin
                if (w_in_xfer) begin
                    w_data_nxt  = i_data;
                    w_last_nxt  = i_data;
                    w_valid_nxt = 1'b1;
                    w_sol_nxt   = 1'b1;
                    w_sof_nxt   = (r_row == '0);
                    w_col_nxt   = COL_W'(1);
                    w_state_nxt = S_LPAD;
                end
            end
            S_LPAD: begin
                // o_data keeps p0: the same value serves as the first body beat.
                if (w_out_xfer) begin
                    w_sol_nxt   = 1'b0;
                    w_sof_nxt   = 1'b0;
                    w_state_nxt = S_BODY;
                end
            end
            S_BODY: begin
                if (w_out_xfer && (r_col == COL_LAST)) begin
                    w_data_nxt  = r_last;
                    w_eol_nxt   = 1'b1;
                    w_eof_nxt   = (r_row == ROW_LAST);
                    w_state_nxt = S_RPAD;
                end else if (w_in_xfer) begin
                    w_data_nxt  = i_data;
                    w_last_nxt  = i_data;
                    w_col_nxt   = r_col + COL_W'(1);
                    w_valid_nxt = 1'b1;
                end else if (w_out_xfer) begin
                    w_valid_nxt = 1'b0;
                end
            end
            S_RPAD: begin
                if (w_out_xfer) begin
                    w_valid_nxt = 1'b0;
                    w_eol_nxt   = 1'b0;
                    w_eof_nxt   = 1'b0;
                    w_col_nxt   = '0;
                    w_row_nxt   = (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_ready = w_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_sol   = r_sol;
    assign o_eol   = r_eol;
    assign o_sof   = r_sof;
    assign o_eof   = r_eof;

endmodule
